// File: rtl/eth_seq_pkg.sv
// Shared definitions for the Ethernet TX sequencer: register map, FSM states,
// error codes and the legal frame-length check.
package eth_seq_pkg;

   localparam logic [3:0]  REG_MAC_LO  = 4'h0;
   localparam logic [3:0]  REG_MAC_HI  = 4'h4;
   localparam logic [3:0]  REG_TX_CTRL = 4'h8;

   localparam logic [10:0] LEN_MIN = 11'd60;
   localparam logic [10:0] LEN_MAX = 11'd1514;

   typedef enum logic [2:0] {
      ST_INIT_LO,
      ST_INIT_HI,
      ST_IDLE,
      ST_KICK,
      ST_POLL,
      ST_GAP
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_BUS     = 2'd3
   } err_e;

   function automatic logic len_ok(input logic [10:0] len);
      return (len >= LEN_MIN) && (len <= LEN_MAX);
   endfunction

endpackage

// File: rtl/eth_seq_reg_req.sv
// REG_BUS request holder: latches a request on start_i and keeps every field
// stable until the slave acknowledges with reg_ready_i.
module eth_seq_reg_req
   import eth_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [3:0]  addr_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        reg_ready_i,
   output logic        done_o,
   output logic        busy_o,
   output logic [3:0]  reg_addr_o,
   output logic        reg_write_o,
   output logic [31:0] reg_wdata_o,
   output logic [3:0]  reg_wstrb_o,
   output logic        reg_valid_o
);

   logic        valid_q, valid_d;
   logic [3:0]  addr_q, addr_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      if (valid_q) begin
         if (reg_ready_i) valid_d = 1'b0;
      end else if (start_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         write_d = write_i;
         wdata_d = wdata_i;
         wstrb_d = wstrb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Ready with no request outstanding is simply ignored.
   assign done_o      = valid_q & reg_ready_i;
   assign busy_o      = valid_q;
   assign reg_valid_o = valid_q;
   assign reg_addr_o  = addr_q;
   assign reg_write_o = write_q;
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = wstrb_q;

endmodule

// File: rtl/eth_tx_sequencer.sv
// Drives eth_rgmii over REG_BUS: programs the station MAC, then per descriptor
// kicks a transmit, polls the busy flag and enforces an inter-packet gap.
module eth_tx_sequencer
   import eth_seq_pkg::*;
#(
   parameter logic [47:0] MacAddr     = 48'h4000_0089_0702,
   parameter logic [31:0] TxCtrlBits  = 32'h0020_5000,
   parameter int unsigned BusyBit     = 11,
   parameter int unsigned PollTimeout = 4096,
   parameter int unsigned GapCycles   = 12
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        desc_valid_i,
   output logic        desc_ready_o,
   input  logic [10:0] desc_len_i,
   output logic [3:0]  reg_addr_o,
   output logic        reg_write_o,
   output logic [31:0] reg_wdata_o,
   output logic [3:0]  reg_wstrb_o,
   output logic        reg_valid_o,
   input  logic [31:0] reg_rdata_i,
   input  logic        reg_ready_i,
   input  logic        reg_error_i,
   output logic        init_done_o,
   output logic        tx_done_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   localparam int PCW = (PollTimeout > 1) ? $clog2(PollTimeout + 1) : 1;
   localparam int GCW = (GapCycles > 1) ? $clog2(GapCycles + 1) : 1;

   state_e         state_q, state_d;
   logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
   logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
   logic [10:0]    len_q, len_d;
   logic           init_done_q, init_done_d;
   logic           tx_done_q, tx_done_d;
   logic           err_q, err_d;
   err_e           err_code_q, err_code_d;
   logic           desc_ready_q, desc_ready_d;

   logic           req_start, req_write, req_done, req_busy;
   logic [3:0]     req_addr, req_wstrb;
   logic [31:0]    req_wdata;
   logic           tx_busy;
   logic           rdata_unused;

   assign tx_busy      = reg_rdata_i[BusyBit];
   assign rdata_unused = ^reg_rdata_i;

   // A new request is issued on the first cycle of a bus state with no request
   // outstanding; after each completion the bus idles one cycle.
   always_comb begin
      req_start = 1'b0;
      req_addr  = REG_TX_CTRL;
      req_write = 1'b0;
      req_wdata = '0;
      req_wstrb = 4'h0;
      case (state_q)
         ST_INIT_LO: begin
            req_start = ~req_busy;
            req_addr  = REG_MAC_LO;
            req_write = 1'b1;
            req_wdata = MacAddr[31:0];
            req_wstrb = 4'hF;
         end
         ST_INIT_HI: begin
            req_start = ~req_busy;
            req_addr  = REG_MAC_HI;
            req_write = 1'b1;
            req_wdata = {16'h0, MacAddr[47:32]};
            req_wstrb = 4'hF;
         end
         ST_KICK: begin
            req_start = ~req_busy;
            req_write = 1'b1;
            req_wdata = TxCtrlBits | {21'h0, len_q};
            req_wstrb = 4'hF;
         end
         ST_POLL: req_start = ~req_busy;
         default: ;
      endcase
   end

   eth_seq_reg_req u_reg_req (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (req_start),
      .addr_i      (req_addr),
      .write_i     (req_write),
      .wdata_i     (req_wdata),
      .wstrb_i     (req_wstrb),
      .reg_ready_i (reg_ready_i),
      .done_o      (req_done),
      .busy_o      (req_busy),
      .reg_addr_o  (reg_addr_o),
      .reg_write_o (reg_write_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_wstrb_o (reg_wstrb_o),
      .reg_valid_o (reg_valid_o)
   );

   always_comb begin
      state_d     = state_q;
      poll_cnt_d  = poll_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      len_d       = len_q;
      init_done_d = init_done_q;
      tx_done_d   = 1'b0;
      err_d       = err_q;
      err_code_d  = err_code_q;

      case (state_q)
         ST_INIT_LO: begin
            if (req_done) begin
               if (reg_error_i) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BUS;
               end
               state_d = ST_INIT_HI;
            end
         end
         ST_INIT_HI: begin
            if (req_done) begin
               if (reg_error_i) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BUS;
               end
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (desc_valid_i && desc_ready_q) begin
               if (len_ok(desc_len_i)) begin
                  len_d   = desc_len_i;
                  state_d = ST_KICK;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
               end
            end
         end
         ST_KICK: begin
            if (req_done) begin
               poll_cnt_d = '0;
               if (reg_error_i) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BUS;
                  state_d    = ST_GAP;
               end else begin
                  state_d = ST_POLL;
               end
            end
         end
         ST_POLL: begin
            if (req_done) begin
               poll_cnt_d = poll_cnt_q + PCW'(1);
               if (reg_error_i) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BUS;
                  state_d    = ST_GAP;
               end else if (!tx_busy) begin
                  tx_done_d = 1'b1;
                  state_d   = ST_GAP;
               end else if ((32'(poll_cnt_q) + 32'd1) >= PollTimeout) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_TIMEOUT;
                  state_d    = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            // GapCycles of zero still spends the single transition cycle here.
            if ((32'(gap_cnt_q) + 32'd1) >= GapCycles) state_d = ST_IDLE;
            else gap_cnt_d = gap_cnt_q + GCW'(1);
         end
         default: state_d = ST_INIT_LO;
      endcase

      if (state_d == ST_GAP && state_q != ST_GAP) gap_cnt_d = '0;
      desc_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= ST_INIT_LO;
         poll_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         len_q        <= '0;
         init_done_q  <= 1'b0;
         tx_done_q    <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
         desc_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         poll_cnt_q   <= poll_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         len_q        <= len_d;
         init_done_q  <= init_done_d;
         tx_done_q    <= tx_done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         desc_ready_q <= desc_ready_d;
      end
   end

   assign desc_ready_o = desc_ready_q;
   assign init_done_o  = init_done_q;
   assign tx_done_o    = tx_done_q;
   assign err_o        = err_q;
   assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Bench for eth_tx_sequencer: a REG_BUS responder with optional random stalls,
// a transfer log, and an expected-transaction model built from the frame rules.
module tb_eth_tx_sequencer;

   localparam logic [47:0] MAC      = 48'h4000_0089_0702;
   localparam logic [31:0] CTRL     = 32'h0020_5000;
   localparam int          BUSY_BIT = 11;
   localparam int          POLL_TO  = 4096;
   localparam int          GAP      = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        desc_valid_i = 1'b0;
   logic        desc_ready_o;
   logic [10:0] desc_len_i = '0;
   logic [3:0]  reg_addr_o;
   logic        reg_write_o;
   logic [31:0] reg_wdata_o;
   logic [3:0]  reg_wstrb_o;
   logic        reg_valid_o;
   logic [31:0] reg_rdata_i = '0;
   logic        reg_ready_i = 1'b0;
   logic        reg_error_i = 1'b0;
   logic        init_done_o, tx_done_o, err_o;
   logic [1:0]  err_code_o;

   eth_tx_sequencer #(
      .MacAddr(MAC), .TxCtrlBits(CTRL), .BusyBit(BUSY_BIT),
      .PollTimeout(POLL_TO), .GapCycles(GAP)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_len_i(desc_len_i),
      .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
      .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o),
      .reg_rdata_i(reg_rdata_i), .reg_ready_i(reg_ready_i), .reg_error_i(reg_error_i),
      .init_done_o(init_done_o), .tx_done_o(tx_done_o), .err_o(err_o), .err_code_o(err_code_o)
   );

   always #5 clk = ~clk;

   // {write, addr, wdata, wstrb}
   typedef logic [40:0] xfer_t;

   xfer_t log_q[$];
   int    reads_total = 0;
   int    tx_pulses = 0;
   int    busy_n = 0;
   int    read_base = 0;
   bit    stall = 1'b0;
   bit    err_inj = 1'b0;
   int    checks = 0;
   int    failures = 0;
   logic  [1:0] exp_code = 2'd0;
   logic  exp_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transfer log, tx_done counter and request-hold check on each active edge.
   logic  prev_pend = 1'b0;
   xfer_t prev_fields = '0;
   always @(posedge clk) begin
      if (prev_pend) begin
         chk("hold_valid", reg_valid_o, 1'b1);
         chk("hold_fields", {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o}, prev_fields);
      end
      if (rst_n && reg_valid_o && reg_ready_i) begin
         log_q.push_back({reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o});
         if (!reg_write_o) reads_total++;
      end
      if (rst_n && tx_done_o) tx_pulses++;
      prev_pend   = rst_n && reg_valid_o && !reg_ready_i;
      prev_fields = {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o};
   end

   // Slave model: reads report busy for the first busy_n polls of a packet.
   bit pend = 1'b0;
   int wait_cnt = 0;
   always @(negedge clk) begin
      if (!reg_valid_o) pend = 1'b0;
      else if (!pend) begin
         pend = 1'b1;
         wait_cnt = stall ? int'($urandom_range(5, 0)) : 0;
      end
      if (pend && wait_cnt == 0) begin
         reg_ready_i = 1'b1;
         reg_error_i = err_inj;
         reg_rdata_i = $urandom;
         reg_rdata_i[BUSY_BIT] = ((reads_total - read_base) < busy_n);
      end else begin
         reg_ready_i = pend ? 1'b0 : (stall ? 1'($urandom_range(1, 0)) : 1'b1);
         reg_error_i = stall ? 1'($urandom_range(1, 0)) : 1'b0;
         reg_rdata_i = $urandom;
         if (pend) wait_cnt--;
      end
   end

   task automatic check_reset_outputs();
      chk("rst_valid", reg_valid_o, 1'b0);
      chk("rst_write", reg_write_o, 1'b0);
      chk("rst_addr", reg_addr_o, 4'h0);
      chk("rst_wdata", reg_wdata_o, 32'h0);
      chk("rst_wstrb", reg_wstrb_o, 4'h0);
      chk("rst_desc_ready", desc_ready_o, 1'b0);
      chk("rst_init_done", init_done_o, 1'b0);
      chk("rst_tx_done", tx_done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_err_code", err_code_o, 2'd0);
   endtask

   task automatic wait_init(input int base);
      int n = 0;
      bit mid_checked = 1'b0;
      while (log_q.size() < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
         if (log_q.size() == base + 1 && !mid_checked) begin
            chk("init_done_early", init_done_o, 1'b0);
            mid_checked = 1'b1;
         end
      end
      chk("init_in_time", (n < 200), 1'b1);
      chk("init_done_after_ack", init_done_o, 1'b1);
      if (log_q.size() >= base + 2) begin
         chk("init_lo_xfer", log_q[base], {1'b1, 4'h0, MAC[31:0], 4'hF});
         chk("init_hi_xfer", log_q[base + 1], {1'b1, 4'h4, 16'h0, MAC[47:32], 4'hF});
      end
   endtask

   task automatic send_desc(input logic [10:0] len);
      int n = 0;
      while (!desc_ready_o && n < 1000) begin @(negedge clk); n++; end
      chk("desc_ready_wait", desc_ready_o, 1'b1);
      desc_valid_i = 1'b1;
      desc_len_i   = len;
      @(negedge clk);
      desc_valid_i = 1'b0;
   endtask

   task automatic run_pkt(input logic [10:0] len, input int bn, input bit st, input bit ei);
      int base, txb, n, t_done, reads, bad;
      bit good, exp_tx;
      stall = st; err_inj = ei; busy_n = bn;
      read_base = reads_total;
      base = log_q.size();
      txb  = tx_pulses;
      send_desc(len);
      n = 0; t_done = -1;
      do begin
         @(negedge clk);
         n++;
         if (tx_done_o && t_done < 0) t_done = n;
      end while (!desc_ready_o && n < 20000);
      chk("pkt_return_idle", desc_ready_o, 1'b1);

      good   = (len >= 60) && (len <= 1514);
      reads  = (good && !ei) ? ((bn + 1 < POLL_TO) ? bn + 1 : POLL_TO) : 0;
      exp_tx = good && !ei && (bn < POLL_TO);
      if (!good) begin exp_code = 2'd1; exp_err = 1'b1; end
      else if (ei) begin exp_code = 2'd3; exp_err = 1'b1; end
      else if (!exp_tx) begin exp_code = 2'd2; exp_err = 1'b1; end

      chk("pkt_xfer_count", log_q.size() - base, (good ? 1 + reads : 0));
      if (good && log_q.size() > base)
         chk("pkt_kick_xfer", log_q[base], {1'b1, 4'h8, CTRL | {21'h0, len}, 4'hF});
      bad = 0;
      for (int i = base + 1; i < log_q.size(); i++)
         if (log_q[i] !== {1'b0, 4'h8, 32'h0, 4'h0}) bad++;
      chk("pkt_poll_xfers", bad, 0);
      chk("pkt_tx_done_pulses", tx_pulses - txb, exp_tx);
      if (exp_tx) chk("pkt_gap_cycles", n - t_done, GAP);
      chk("pkt_err_code", err_code_o, exp_code);
      chk("pkt_err", err_o, exp_err);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      wait_init(0);

      run_pkt(11'd64, 3, 1'b0, 1'b0);
      run_pkt(11'd20, 0, 1'b0, 1'b0);
      run_pkt(11'd1600, 0, 1'b0, 1'b0);
      run_pkt(11'd59, 0, 1'b0, 1'b0);
      run_pkt(11'd1515, 0, 1'b0, 1'b0);
      run_pkt(11'd60, 0, 1'b0, 1'b0);
      run_pkt(11'd1514, 2, 1'b1, 1'b0);
      run_pkt(11'd200, 1, 1'b0, 1'b1);

      for (int k = 0; k < 8; k++)
         run_pkt(11'($urandom_range(1514, 60)), int'($urandom_range(8, 0)),
                 1'($urandom_range(1, 0)), 1'b0);
      for (int k = 0; k < 3; k++)
         run_pkt((k == 1) ? 11'($urandom_range(2047, 1515)) : 11'($urandom_range(59, 0)),
                 0, 1'b0, 1'b0);

      run_pkt(11'd128, 100000, 1'b0, 1'b0);
      run_pkt(11'd90, 4095, 1'b0, 1'b0);

      // Reset while polling a stuck-busy packet.
      stall = 1'b1; busy_n = 100000; read_base = reads_total;
      send_desc(11'd300);
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      exp_code = 2'd0; exp_err = 1'b0;
      stall = 1'b0;
      rst_n = 1'b1;
      wait_init(log_q.size());
      run_pkt(11'd777, 2, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_tx_sequencer.md
ETH_TX_SEQUENCER -- requirements
Module: eth_tx_sequencer

Interface
REQ-001 SHALL have parameter MacAddr, 48'h0000_4000_0089_0702 default, station MAC programmed at init.
REQ-002 SHALL have parameter TxCtrlBits, 32'h0020_5000 default, control bits ORed into every kick word.
REQ-003 SHALL have parameter BusyBit, 11 default, index of TX-busy flag in register 0x8 readback.
REQ-004 SHALL have parameter PollTimeout, 4096 default, maximum busy polls per packet.
REQ-005 SHALL have parameter GapCycles, 12 default, idle cycles between end of one packet and next kick.
REQ-006 SHALL have one clock and a synchronous active-low reset: clk_i in 1 system clock; rst_ni in 1 synchronous active-low reset.
REQ-007 SHALL have desc_valid_i in 1, desc_ready_o out 1, desc_len_i in 11: packet descriptor handshake and byte length.
REQ-008 SHALL have reg_addr_o out 4, reg_write_o out 1, reg_wdata_o out 32, reg_wstrb_o out 4, reg_valid_o out 1: REG_BUS request to eth_rgmii.
REQ-009 SHALL have reg_rdata_i in 32, reg_ready_i in 1, reg_error_i in 1: REG_BUS response.
REQ-010 SHALL have init_done_o out 1 (level), tx_done_o out 1 (1-cycle pulse), err_o out 1 (sticky), err_code_o out 2.

Function
REQ-011 SHALL run FSM states INIT_LO, INIT_HI, IDLE, KICK, POLL, GAP.
REQ-012 SHALL write MacAddr[31:0] to 0x0 in INIT_LO, then {16'h0, MacAddr[47:32]} to 0x4 in INIT_HI, wstrb 4'hF, then go to IDLE and set init_done_o.
REQ-013 SHALL hold reg_valid_o and all request fields stable from assertion until the cycle reg_ready_i=1; transfer completes in that cycle.
REQ-014 SHALL assert desc_ready_o only in IDLE; accept a descriptor on desc_valid_i & desc_ready_o.
REQ-015 SHALL reject descriptors with len<60 or len>1514: no bus access, err_code_o=2'd1, err_o set, stay in IDLE.
REQ-016 SHALL, for a valid descriptor, enter KICK next cycle and write TxCtrlBits | {21'h0, len} to 0x8.
REQ-017 SHALL, in POLL, issue reads of 0x8 (reg_write_o=0, wstrb 4'h0); stay while reg_rdata_i[BusyBit]=1, exit to GAP on first completed read with it 0.
REQ-018 SHALL pulse tx_done_o for 1 cycle on POLL->GAP transition.
REQ-019 SHALL count completed polls; on reaching PollTimeout set err_code_o=2'd2, err_o, no tx_done_o, go to GAP.
REQ-020 SHALL, on reg_error_i=1 at any completed transfer, set err_code_o=2'd3 and err_o; init errors still advance; KICK/POLL errors go to GAP without tx_done_o.
REQ-021 SHALL stay in GAP exactly GapCycles cycles, then return to IDLE; GapCycles=0 returns next cycle.
REQ-022 SHALL keep err_code_o as the latest error; err_o clears only by reset.
REQ-023 SHALL tolerate reg_ready_i=1 with reg_valid_o=0 (ignored).

Reset
REQ-024 SHALL on rst_ni=0 at clk_i edge: state INIT_LO, reg_valid_o=0, reg_write_o=0, reg_addr_o=0, reg_wdata_o=0, reg_wstrb_o=0, desc_ready_o=0, init_done_o=0, tx_done_o=0, err_o=0, err_code_o=0, counters 0.
REQ-025 SHALL abandon any in-flight REG_BUS transfer on reset and rerun init afterwards.

Structure
REQ-026 SHALL place register offsets (0x0/0x4/0x8), state enum, and err_code values in shared package eth_seq_pkg.
REQ-027 SHALL use one sub-module, eth_seq_reg_req, owning the REG_BUS request hold/handshake; FSM and counters stay in top.

Verification
REQ-028 SHALL check reset release with reg_ready_i=1 every cycle -> writes 0x0=32'h0089_0702, 0x4=32'h0000_4000; init_done_o high cycle after second ack.
REQ-029 SHALL check desc_len_i=64, busy read 1 three times then 0 -> write 0x8=32'h0020_5040, 4 reads, one tx_done_o pulse, desc_ready_o after 12 GAP cycles.
REQ-030 SHALL check desc_len_i=20 and 1600 -> no bus traffic, err_code_o=1, err_o=1.
REQ-031 SHALL check busy stuck at 1 -> exactly 4096 reads, err_code_o=2, no tx_done_o, return to IDLE.
REQ-032 SHALL check reg_ready_i delayed 5 cycles with random stalls -> request fields stable while reg_valid_o=1.
REQ-033 SHALL check rst_ni low during POLL -> all outputs at reset values, init sequence reissued.
